mem_access: RTL and testbench

- Memory-access stage of the Venus pipeline. It is the downstream receiver of execute's v/stall pipeline handshake.
- Performs word loads and stores against the data memory, a 32x64k single-port synchronous RAM with one-cycle read latency.
- Drives the register-file writeback port: wb / wb_rd_name / wb_rd_data.
- ALU results pass through it, so every register-file write comes from this stage.

---
 rtl/mem_access_if.sv | 17 +
 rtl/mem_access.sv | 94 +++++++++
 tb/tb_mem_access.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Request handshake between execute (master) and the memory-access stage (slave).
interface mem_access_if #(
    parameter int unsigned W_WORD = 32,
    parameter int unsigned W_ADDR = 16,
    parameter int unsigned W_RD   = 5
);
    logic              v;
    logic              stall;
    logic [1:0]        op;
    logic [W_ADDR-1:0] addr;
    logic [W_WORD-1:0] data;
    logic              wb;
    logic [W_RD-1:0]   wb_rd_name;

    modport master (output v, op, addr, data, wb, wb_rd_name, input stall);
    modport slave  (input v, op, addr, data, wb, wb_rd_name, output stall);
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: word loads/stores against a one-cycle-latency RAM and
// the single source of register-file writebacks.
module mem_access #(
    parameter int unsigned W_WORD = 32,
    parameter int unsigned W_ADDR = 16,
    parameter int unsigned W_RD   = 5,
    parameter int unsigned W_CNT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_if.slave       req,
    output logic [W_ADDR-1:0] mem_a_o,
    output logic              mem_w_o,
    output logic [W_WORD-1:0] mem_d_o,
    input  logic [W_WORD-1:0] mem_q_i,
    output logic              wb_o,
    output logic [W_RD-1:0]   wb_rd_name_o,
    output logic [W_WORD-1:0] wb_rd_data_o,
    output logic [W_CNT-1:0]  ld_cnt_o,
    output logic [W_CNT-1:0]  st_cnt_o
);
    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    typedef enum logic [0:0] {IDLE, LOAD_WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              ld_wb_q;
    logic [W_RD-1:0]   ld_name_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept && req.op == OP_LOAD) state_nxt = LOAD_WAIT;
            LOAD_WAIT: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Memory sees the request on the same edge that accepts it.
    always_comb begin
        accept    = 1'b0;
        req.stall = 1'b0;
        mem_w_o   = 1'b0;
        mem_a_o   = req.addr;
        mem_d_o   = req.data;
        accept    = (state == IDLE) && req.v;
        req.stall = (state == LOAD_WAIT);
        mem_w_o   = rst && accept && (req.op == OP_STORE);
    end

    // Writeback port, held load destination and access counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_o         <= 1'b0;
            wb_rd_name_o <= '0;
            wb_rd_data_o <= '0;
            ld_wb_q      <= 1'b0;
            ld_name_q    <= '0;
            ld_cnt_o     <= '0;
            st_cnt_o     <= '0;
        end else begin
            wb_o <= 1'b0;
            if (state == LOAD_WAIT) begin
                wb_o         <= ld_wb_q;
                wb_rd_name_o <= ld_name_q;
                wb_rd_data_o <= mem_q_i;
            end else if (accept) begin
                case (req.op)
                    OP_PASS: begin
                        wb_o         <= req.wb;
                        wb_rd_name_o <= req.wb_rd_name;
                        wb_rd_data_o <= req.data;
                    end
                    OP_LOAD: begin
                        ld_wb_q   <= req.wb;
                        ld_name_q <= req.wb_rd_name;
                        ld_cnt_o  <= ld_cnt_o + W_CNT'(1);
                    end
                    OP_STORE: st_cnt_o <= st_cnt_o + W_CNT'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus a randomized run
// against a cycle-stamped transaction model.
module tb_mem_access;
    localparam int unsigned W_WORD = 32;
    localparam int unsigned W_ADDR = 16;
    localparam int unsigned W_RD   = 5;
    localparam int unsigned W_CNT  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [W_ADDR-1:0] mem_a;
    logic              mem_w;
    logic [W_WORD-1:0] mem_d;
    logic [W_WORD-1:0] mem_q = '0;
    logic              wb;
    logic [W_RD-1:0]   wb_rd_name;
    logic [W_WORD-1:0] wb_rd_data;
    logic [W_CNT-1:0]  ld_cnt;
    logic [W_CNT-1:0]  st_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_ld = 0;
    int exp_st = 0;

    logic [31:0] ram [0:65535];
    logic [31:0] ref_mem [int];

    mem_access_if #(.W_WORD(W_WORD), .W_ADDR(W_ADDR), .W_RD(W_RD)) bus ();

    mem_access #(.W_WORD(W_WORD), .W_ADDR(W_ADDR), .W_RD(W_RD), .W_CNT(W_CNT)) dut (
        .clk(clk), .rst(rst), .req(bus.slave),
        .mem_a_o(mem_a), .mem_w_o(mem_w), .mem_d_o(mem_d), .mem_q_i(mem_q),
        .wb_o(wb), .wb_rd_name_o(wb_rd_name), .wb_rd_data_o(wb_rd_data),
        .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_w) ram[mem_a] <= mem_d;
        mem_q <= ram[mem_a];
    end

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_read(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // Drive one cycle's request; returns #1 after the falling edge.
    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a,
                         input logic [31:0] d, input logic w, input logic [4:0] rd);
        @(negedge clk);
        bus.v = v; bus.op = op; bus.addr = a; bus.data = d; bus.wb = w; bus.wb_rd_name = rd;
        #1;
    endtask

    task automatic test_reset();
        bus.v = 1'b1; bus.op = 2'b10; bus.addr = 16'h0040; bus.data = 32'hCAFEF00D;
        bus.wb = 1'b1; bus.wb_rd_name = 5'd4;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (mem_w !== 1'b0) begin n_fail++; $display("FAIL reset_mem_w: got %b expected 0", mem_w); end
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        n_chk++; if (wb !== 1'b0) begin n_fail++; $display("FAIL reset_wb: got %b expected 0", wb); end
        n_chk++; if (wb_rd_name !== 5'd0 || wb_rd_data !== 32'd0) begin n_fail++;
            $display("FAIL reset_wb_regs: got name %0d data %h expected 0 0", wb_rd_name, wb_rd_data); end
        n_chk++; if (ld_cnt !== 4'd0 || st_cnt !== 4'd0) begin n_fail++;
            $display("FAIL reset_counters: got ld %0d st %0d expected 0 0", ld_cnt, st_cnt); end
        @(negedge clk);
        bus.v = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_pass();
        drive(1'b1, 2'b00, 16'h0000, 32'hDEADBEEF, 1'b1, 5'd3);
        n_chk++; if (mem_w !== 1'b0) begin n_fail++; $display("FAIL pass_mem_w: got %b expected 0", mem_w); end
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (wb !== 1'b1 || wb_rd_name !== 5'd3 || wb_rd_data !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL pass_wb: got %b/%0d/%h expected 1/3/deadbeef", wb, wb_rd_name, wb_rd_data); end
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (wb !== 1'b0) begin n_fail++; $display("FAIL pass_pulse: got %b expected 0", wb); end
    endtask

    task automatic test_store_load();
        drive(1'b1, 2'b10, 16'h0040, 32'h12345678, 1'b0, 5'd0);
        n_chk++; if (mem_w !== 1'b1) begin n_fail++; $display("FAIL store_mem_w: got %b expected 1", mem_w); end
        ref_mem[16'h0040] = 32'h12345678; exp_st++;
        drive(1'b1, 2'b01, 16'h0040, 32'h0, 1'b1, 5'd7);
        n_chk++; if (bus.stall !== 1'b0 || wb !== 1'b0) begin n_fail++;
            $display("FAIL store_next: got stall %b wb %b expected 0 0", bus.stall, wb); end
        exp_ld++;
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (bus.stall !== 1'b1 || wb !== 1'b0) begin n_fail++;
            $display("FAIL load_wait: got stall %b wb %b expected 1 0", bus.stall, wb); end
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (wb !== 1'b1 || wb_rd_name !== 5'd7 || wb_rd_data !== 32'h12345678) begin n_fail++;
            $display("FAIL load_wb: got %b/%0d/%h expected 1/7/12345678", wb, wb_rd_name, wb_rd_data); end
        n_chk++; if (st_cnt !== 4'd1 || ld_cnt !== 4'd1) begin n_fail++;
            $display("FAIL store_load_cnt: got st %0d ld %0d expected 1 1", st_cnt, ld_cnt); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'b01, 16'h0040, 32'h0, 1'b1, 5'd1);
        exp_ld++;
        drive(1'b1, 2'b00, 16'h0000, 32'h0000A5A5, 1'b1, 5'd2);
        n_chk++; if (bus.stall !== 1'b1 || wb !== 1'b0) begin n_fail++;
            $display("FAIL bp_held: got stall %b wb %b expected 1 0", bus.stall, wb); end
        drive(1'b1, 2'b00, 16'h0000, 32'h0000A5A5, 1'b1, 5'd2);
        n_chk++; if (wb !== 1'b1 || wb_rd_name !== 5'd1 || wb_rd_data !== 32'h12345678 || bus.stall !== 1'b0) begin n_fail++;
            $display("FAIL bp_load_wb: got %b/%0d/%h stall %b expected 1/1/12345678 0", wb, wb_rd_name, wb_rd_data, bus.stall); end
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (wb !== 1'b1 || wb_rd_name !== 5'd2 || wb_rd_data !== 32'h0000A5A5) begin n_fail++;
            $display("FAIL bp_pass_wb: got %b/%0d/%h expected 1/2/a5a5", wb, wb_rd_name, wb_rd_data); end
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (wb !== 1'b0) begin n_fail++; $display("FAIL bp_pulse: got %b expected 0", wb); end
    endtask

    task automatic test_load_nowb();
        drive(1'b1, 2'b01, 16'hFFFF, 32'h0, 1'b0, 5'd9);
        exp_ld++;
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (bus.stall !== 1'b1 || wb !== 1'b0) begin n_fail++;
            $display("FAIL nowb_wait: got stall %b wb %b expected 1 0", bus.stall, wb); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
            n_chk++; if (bus.stall !== 1'b0 || wb !== 1'b0) begin n_fail++;
                $display("FAIL nowb_after%0d: got stall %b wb %b expected 0 0", i, bus.stall, wb); end
        end
        n_chk++; if (ld_cnt !== 4'(exp_ld)) begin n_fail++;
            $display("FAIL nowb_ld_cnt: got %0d expected %0d", ld_cnt, exp_ld); end
    endtask

    task automatic test_nop();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 16'h0040, 32'h13572468, 1'b1, 5'd30);
            n_chk++; if (wb !== 1'b0 || mem_w !== 1'b0) begin n_fail++;
                $display("FAIL nop_%0d: got wb %b mem_w %b expected 0 0", i, wb, mem_w); end
        end
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (wb_rd_name !== 5'd9 || wb_rd_data !== init_word(16'hFFFF)) begin n_fail++;
            $display("FAIL nop_hold: got %0d/%h expected 9/%h", wb_rd_name, wb_rd_data, init_word(16'hFFFF)); end
        n_chk++; if (ld_cnt !== 4'(exp_ld) || st_cnt !== 4'(exp_st)) begin n_fail++;
            $display("FAIL nop_cnt: got ld %0d st %0d expected %0d %0d", ld_cnt, st_cnt, exp_ld, exp_st); end
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'b10, 16'(16'h0100 + i), 32'(i), 1'b0, 5'd0);
            n_chk++; if (mem_w !== 1'b1) begin n_fail++; $display("FAIL wrap_mem_w%0d: got %b expected 1", i, mem_w); end
            ref_mem[16'h0100 + i] = 32'(i);
            exp_st++;
        end
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (st_cnt !== 4'(exp_st) || ld_cnt !== 4'(exp_ld)) begin n_fail++;
            $display("FAIL wrap_cnt: got st %0d ld %0d expected %0d %0d", st_cnt, ld_cnt, exp_st % 16, exp_ld % 16); end
    endtask

    task automatic test_reset_mid_load();
        drive(1'b1, 2'b01, 16'h0040, 32'h0, 1'b1, 5'd5);
        drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
        n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rml_stall: got %b expected 1", bus.stall); end
        #2 rst = 1'b0;
        #1;
        exp_ld = 0; exp_st = 0;
        n_chk++; if (bus.stall !== 1'b0 || wb !== 1'b0 || ld_cnt !== 4'd0 || st_cnt !== 4'd0) begin n_fail++;
            $display("FAIL rml_async: got stall %b wb %b ld %0d st %0d expected 0 0 0 0", bus.stall, wb, ld_cnt, st_cnt); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 16'h0000, 32'h0, 1'b0, 5'd0);
            n_chk++; if (wb !== 1'b0 || bus.stall !== 1'b0) begin n_fail++;
                $display("FAIL rml_after%0d: got wb %b stall %b expected 0 0", i, wb, bus.stall); end
        end
    endtask

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] d; } exp_t;

    // Model: each accepted request stamps when its writeback is due; a load
    // blocks acceptance for the following cycle.
    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          free_c = 0;
        logic        held = 1'b0;
        logic        acc;
        logic        v = 1'b0;
        logic [1:0]  op = 2'b00;
        logic [15:0] a = '0;
        logic [31:0] d = '0;
        logic        w = 1'b0;
        logic [4:0]  rd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!held) begin
                v  = ($urandom % 4) != 0;
                op = 2'($urandom % 4);
                a  = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
                d  = $urandom;
                w  = 1'($urandom % 2);
                rd = 5'($urandom % 32);
            end
            drive(v, op, a, d, w, rd);
            acc = v && (c >= free_c);
            n_chk++; if (bus.stall !== (c < free_c)) begin n_fail++;
                $display("FAIL rnd_stall c%0d: got %b expected %b", c, bus.stall, (c < free_c)); end
            n_chk++; if (mem_w !== (acc && op == 2'b10)) begin n_fail++;
                $display("FAIL rnd_mem_w c%0d: got %b expected %b", c, mem_w, (acc && op == 2'b10)); end
            if (q.size() > 0 && q[0].cyc == c) begin
                e = q.pop_front();
                n_chk++; if (wb !== 1'b1 || wb_rd_name !== e.rd || wb_rd_data !== e.d) begin n_fail++;
                    $display("FAIL rnd_wb c%0d: got %b/%0d/%h expected 1/%0d/%h", c, wb, wb_rd_name, wb_rd_data, e.rd, e.d); end
            end else begin
                n_chk++; if (wb !== 1'b0) begin n_fail++; $display("FAIL rnd_nowb c%0d: got %b expected 0", c, wb); end
            end
            n_chk++; if (ld_cnt !== 4'(exp_ld) || st_cnt !== 4'(exp_st)) begin n_fail++;
                $display("FAIL rnd_cnt c%0d: got ld %0d st %0d expected %0d %0d", c, ld_cnt, st_cnt, exp_ld % 16, exp_st % 16); end
            if (acc) begin
                case (op)
                    2'b00: if (w) q.push_back('{c + 1, rd, d});
                    2'b01: begin
                        exp_ld++;
                        if (w) q.push_back('{c + 2, rd, ref_read(int'(a))});
                        free_c = c + 2;
                    end
                    2'b10: begin
                        ref_mem[int'(a)] = d;
                        exp_st++;
                    end
                    default: ;
                endcase
            end
            held = v && !acc;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = init_word(i);
        bus.v = 1'b0; bus.op = 2'b00; bus.addr = '0; bus.data = '0; bus.wb = 1'b0; bus.wb_rd_name = '0;
        test_reset();
        test_pass();
        test_store_load();
        test_back_to_back();
        test_load_nowb();
        test_nop();
        test_counter_wrap();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
